// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared constants, state encoding and helpers for the HI/LO unit
package hilo_pkg;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  localparam int          ITER_COUNT = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    FIX  = 2'd3
  } state_t;

  function automatic logic is_hilo(input logic [5:0] f);
    return (f == F_MFHI) || (f == F_MTHI) || (f == F_MFLO) || (f == F_MTLO) ||
           (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
  endfunction

  // Magnitude of v when treated as signed, otherwise v unchanged.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/hilo_iter.sv
// rtl/hilo_iter.sv - one combinational step of shift-add multiply or restoring divide
module hilo_iter
  import hilo_pkg::*;
(
  input  logic        div_mode,
  input  logic [63:0] acc,
  input  logic [31:0] opnd,
  output logic [63:0] acc_next
);

  logic [32:0] sum;
  logic [32:0] top;
  logic [31:0] diff;
  logic        ge;

  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    sum      = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    top      = acc[63:31];
    ge       = top >= {1'b0, opnd};
    diff     = ge ? (top[31:0] - opnd) : top[31:0];
    acc_next = div_mode ? {diff, acc[30:0], ge} : {sum, acc[31:1]};
  end

endmodule

// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - MIPS HI/LO unit: iterative MULT/DIV plus MFHI/MFLO/MTHI/MTLO
module hilo_muldiv
  import hilo_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall,
  output logic        Hi,
  output logic        Lo,
  output logic [31:0] HiLo_out,
  output logic [31:0] hi_q,
  output logic [31:0] lo_q
);

  state_t      state, state_next;
  logic [5:0]  cnt;
  logic [63:0] acc, acc_next, prod;
  logic [31:0] opnd, quo, rem, fix_hi, fix_lo;
  logic        op_div, div_zero, neg_res, neg_rem;
  logic        is_mul, is_div, is_signed, accept;

  assign busy  = (state != IDLE);
  assign stall = start && is_hilo(funct) && (busy || (state != IDLE));

  always_comb begin
    is_mul    = (funct == F_MULT) || (funct == F_MULTU);
    is_div    = (funct == F_DIV)  || (funct == F_DIVU);
    is_signed = (funct == F_MULT) || (funct == F_DIV);
    accept    = start && (state == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && is_mul)      state_next = MUL;
        else if (accept && is_div) state_next = (b == 32'd0) ? FIX : DIV;
      end
      MUL, DIV: if (cnt == 6'(ITER_COUNT - 1)) state_next = FIX;
      FIX:      state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  hilo_iter u_iter (
    .div_mode (op_div),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_next)
  );

  // Sign correction and divide-by-zero result applied at the FIX edge.
  always_comb begin
    prod   = neg_res ? -acc : acc;
    quo    = neg_res ? -acc[31:0] : acc[31:0];
    rem    = neg_rem ? -acc[63:32] : acc[63:32];
    fix_hi = prod[63:32];
    fix_lo = prod[31:0];
    if (div_zero) begin
      fix_hi = acc[31:0];
      fix_lo = DIV_ZERO_Q;
    end else if (op_div) begin
      fix_hi = rem;
      fix_lo = quo;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      acc      <= '0;
      opnd     <= '0;
      op_div   <= 1'b0;
      div_zero <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      Hi       <= 1'b0;
      Lo       <= 1'b0;
      HiLo_out <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      Hi <= 1'b0;
      Lo <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          cnt <= '0;
          if (is_mul || is_div) begin
            op_div   <= is_div;
            div_zero <= is_div && (b == 32'd0);
            neg_res  <= is_signed && (a[31] ^ b[31]);
            neg_rem  <= is_signed && a[31];
            opnd     <= is_div ? mag(b, is_signed) : mag(a, is_signed);
            if (is_div) acc <= {32'd0, (b == 32'd0) ? a : mag(a, is_signed)};
            else        acc <= {32'd0, mag(b, is_signed)};
          end
          case (funct)
            F_MTHI: hi_q <= a;
            F_MTLO: lo_q <= a;
            F_MFHI: begin HiLo_out <= hi_q; Hi <= 1'b1; end
            F_MFLO: begin HiLo_out <= lo_q; Lo <= 1'b1; end
            default: ;
          endcase
        end
        MUL, DIV: begin
          acc <= acc_next;
          cnt <= cnt + 6'd1;
        end
        FIX: begin
          cnt  <= '0;
          hi_q <= fix_hi;
          lo_q <= fix_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - directed self-checking bench for hilo_muldiv
module tb_hilo_muldiv;

  localparam logic [5:0] T_MFHI  = 6'h10;
  localparam logic [5:0] T_MTHI  = 6'h11;
  localparam logic [5:0] T_MFLO  = 6'h12;
  localparam logic [5:0] T_MTLO  = 6'h13;
  localparam logic [5:0] T_MULT  = 6'h18;
  localparam logic [5:0] T_MULTU = 6'h19;
  localparam logic [5:0] T_DIV   = 6'h1A;
  localparam logic [5:0] T_DIVU  = 6'h1B;

  logic        clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic [5:0]  funct = '0;
  logic [31:0] a = '0, b = '0;
  logic        busy, stall, Hi, Lo;
  logic [31:0] HiLo_out, hi_q, lo_q;
  int          checks = 0, failures = 0;

  hilo_muldiv dut (
    .clk(clk), .rst(rst), .start(start), .funct(funct), .a(a), .b(b),
    .busy(busy), .stall(stall), .Hi(Hi), .Lo(Lo), .HiLo_out(HiLo_out),
    .hi_q(hi_q), .lo_q(lo_q)
  );

  always #5 clk = ~clk;

  // Called at a falling edge; returns the number of cycles busy was seen high.
  task automatic run_op(input logic [5:0] f, input logic [31:0] x, input logic [31:0] y, output int n);
    start = 1'b1; funct = f; a = x; b = y;
    @(negedge clk);
    start = 1'b0; a = ~x; b = ~y;
    n = 0;
    while (busy && n < 100) begin n++; @(negedge clk); end
  endtask

  task automatic test_reset;
    checks++; if ({busy, stall, Hi, Lo} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b want=0000", {busy, stall, Hi, Lo}); end
    checks++; if ({HiLo_out, hi_q, lo_q} !== 96'd0) begin failures++; $display("FAIL reset_data got=%h want=0", {HiLo_out, hi_q, lo_q}); end
  endtask

  task automatic test_mult;
    int n;
    run_op(T_MULT, 32'hFFFF_FFFE, 32'd3, n);
    checks++; if (n !== 33) begin failures++; $display("FAIL mult_busy got=%0d want=33", n); end
    checks++; if ({hi_q, lo_q} !== 64'hFFFF_FFFF_FFFF_FFFA) begin failures++; $display("FAIL mult_neg got=%h want=fffffffffffffffa", {hi_q, lo_q}); end
    run_op(T_MULT, 32'h8000_0000, 32'h8000_0000, n);
    checks++; if ({hi_q, lo_q} !== 64'h4000_0000_0000_0000) begin failures++; $display("FAIL mult_min got=%h want=4000000000000000", {hi_q, lo_q}); end
    run_op(T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    checks++; if (n !== 33) begin failures++; $display("FAIL multu_busy got=%0d want=33", n); end
    checks++; if ({hi_q, lo_q} !== 64'hFFFF_FFFE_0000_0001) begin failures++; $display("FAIL multu_max got=%h want=fffffffe00000001", {hi_q, lo_q}); end
  endtask

  task automatic test_div;
    int n;
    run_op(T_DIVU, 32'd100, 32'd7, n);
    checks++; if (n !== 33) begin failures++; $display("FAIL divu_busy got=%0d want=33", n); end
    checks++; if ({hi_q, lo_q} !== {32'd2, 32'd14}) begin failures++; $display("FAIL divu_100_7 got=%h want=%h", {hi_q, lo_q}, {32'd2, 32'd14}); end
    run_op(T_DIV, 32'hFFFF_FFF9, 32'd2, n);
    checks++; if ({hi_q, lo_q} !== 64'hFFFF_FFFF_FFFF_FFFD) begin failures++; $display("FAIL div_m7_2 got=%h want=fffffffffffffffd", {hi_q, lo_q}); end
    run_op(T_DIV, 32'd7, 32'hFFFF_FFFE, n);
    checks++; if ({hi_q, lo_q} !== 64'h0000_0001_FFFF_FFFD) begin failures++; $display("FAIL div_7_m2 got=%h want=00000001fffffffd", {hi_q, lo_q}); end
    run_op(T_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
    checks++; if ({hi_q, lo_q} !== 64'h0000_0000_8000_0000) begin failures++; $display("FAIL div_overflow got=%h want=0000000080000000", {hi_q, lo_q}); end
  endtask

  task automatic test_div_zero;
    int n;
    run_op(T_DIV, 32'd5, 32'd0, n);
    checks++; if (n !== 1) begin failures++; $display("FAIL divz_busy got=%0d want=1", n); end
    checks++; if ({hi_q, lo_q} !== {32'd5, 32'hFFFF_FFFF}) begin failures++; $display("FAIL divz_result got=%h want=%h", {hi_q, lo_q}, {32'd5, 32'hFFFF_FFFF}); end
  endtask

  task automatic test_mflo_stall;
    int n;
    logic lo_seen;
    start = 1'b1; funct = T_MULTU; a = 32'd6; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; funct = T_MFLO; a = 32'd0; b = 32'd0;
    #1;
    n = 0; lo_seen = 1'b0;
    while (stall && n < 100) begin n++; if (Lo) lo_seen = 1'b1; @(negedge clk); end
    checks++; if (n !== 29) begin failures++; $display("FAIL mflo_stall_cycles got=%0d want=29", n); end
    checks++; if (lo_seen !== 1'b0) begin failures++; $display("FAIL mflo_early_pulse got=%b want=0", lo_seen); end
    @(negedge clk);
    start = 1'b0;
    checks++; if ({Hi, Lo} !== 2'b01) begin failures++; $display("FAIL mflo_pulse got=%b want=01", {Hi, Lo}); end
    checks++; if (HiLo_out !== 32'd42) begin failures++; $display("FAIL mflo_data got=%0d want=42", HiLo_out); end
    @(negedge clk);
    checks++; if (Lo !== 1'b0) begin failures++; $display("FAIL mflo_single got=%b want=0", Lo); end
  endtask

  task automatic test_mthi_mfhi;
    logic busy_seen;
    start = 1'b1; funct = T_MTHI; a = 32'h1234; b = 32'd0;
    #1;
    busy_seen = busy;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL mthi_stall got=%b want=0", stall); end
    @(negedge clk);
    busy_seen = busy_seen | busy;
    checks++; if (hi_q !== 32'h1234) begin failures++; $display("FAIL mthi_write got=%h want=00001234", hi_q); end
    funct = T_MFHI; a = 32'd0;
    @(negedge clk);
    start = 1'b0;
    busy_seen = busy_seen | busy;
    checks++; if ({Hi, Lo} !== 2'b10) begin failures++; $display("FAIL mfhi_pulse got=%b want=10", {Hi, Lo}); end
    checks++; if (HiLo_out !== 32'h1234) begin failures++; $display("FAIL mfhi_data got=%h want=00001234", HiLo_out); end
    @(negedge clk);
    busy_seen = busy_seen | busy;
    checks++; if (Hi !== 1'b0) begin failures++; $display("FAIL mfhi_single got=%b want=0", Hi); end
    checks++; if (busy_seen !== 1'b0) begin failures++; $display("FAIL mthi_busy got=%b want=0", busy_seen); end
    start = 1'b1; funct = T_MTLO; a = 32'h5678;
    @(negedge clk);
    start = 1'b0;
    checks++; if (lo_q !== 32'h5678) begin failures++; $display("FAIL mtlo_write got=%h want=00005678", lo_q); end
  endtask

  task automatic test_invalid;
    start = 1'b1; funct = 6'h20; a = 32'hFFFF; b = 32'd1;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL invalid_stall got=%b want=0", stall); end
    @(negedge clk);
    start = 1'b0;
    checks++; if ({busy, Hi, Lo} !== 3'b000) begin failures++; $display("FAIL invalid_flags got=%b want=000", {busy, Hi, Lo}); end
    checks++; if ({hi_q, lo_q} !== {32'h1234, 32'h5678}) begin failures++; $display("FAIL invalid_regs got=%h want=%h", {hi_q, lo_q}, {32'h1234, 32'h5678}); end
  endtask

  task automatic test_back_to_back;
    int n;
    run_op(T_MULTU, 32'd1000, 32'd1000, n);
    checks++; if ({hi_q, lo_q} !== {32'd0, 32'd1000000}) begin failures++; $display("FAIL b2b_mul got=%h want=%h", {hi_q, lo_q}, {32'd0, 32'd1000000}); end
    run_op(T_DIVU, 32'd1000001, 32'd1000, n);
    checks++; if (n !== 33) begin failures++; $display("FAIL b2b_div_busy got=%0d want=33", n); end
    checks++; if ({hi_q, lo_q} !== {32'd1, 32'd1000}) begin failures++; $display("FAIL b2b_div got=%h want=%h", {hi_q, lo_q}, {32'd1, 32'd1000}); end
    start = 1'b1; funct = T_MFHI;
    @(negedge clk);
    start = 1'b0;
    checks++; if ({Hi, HiLo_out} !== {1'b1, 32'd1}) begin failures++; $display("FAIL b2b_mfhi got=%h want=%h", {Hi, HiLo_out}, {1'b1, 32'd1}); end
  endtask

  task automatic test_reset_mid;
    int n;
    start = 1'b1; funct = T_DIV; a = 32'hFFFF_FF9C; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b want=1", busy); end
    rst = 1'b0;
    #1;
    checks++; if ({busy, Hi, Lo} !== 3'b000) begin failures++; $display("FAIL rstmid_flags got=%b want=000", {busy, Hi, Lo}); end
    checks++; if ({HiLo_out, hi_q, lo_q} !== 96'd0) begin failures++; $display("FAIL rstmid_data got=%h want=0", {HiLo_out, hi_q, lo_q}); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_hold got=%b want=0", busy); end
    rst = 1'b1;
    @(negedge clk);
    run_op(T_DIVU, 32'd9, 32'd3, n);
    checks++; if (n !== 33) begin failures++; $display("FAIL rstmid_divu_busy got=%0d want=33", n); end
    checks++; if ({hi_q, lo_q} !== {32'd0, 32'd3}) begin failures++; $display("FAIL rstmid_divu got=%h want=%h", {hi_q, lo_q}, {32'd0, 32'd3}); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset;
    rst = 1'b1;
    @(negedge clk);
    test_mult;
    test_div;
    test_div_zero;
    test_mflo_stall;
    test_mthi_mfhi;
    test_invalid;
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
